// File: rtl/enemy_unit.sv
// enemy_unit
// Enemy-side lane unit. It spawns at START_POS, walks one step toward
// END_POS on every moveSCEN tick while the frontmost player unit is still
// ahead of it, and attacks that player unit on a cooldown once in contact.
// Damage strobes reduce its health; a lethal hit sends it through a timed
// dying state before it returns to idle. Reaching END_POS raises a one-cycle
// reachedBase pulse and also returns the unit to idle.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   spawnSCEN          single-cycle spawn request
//   spawnType[1:0]     requested type 1-3 (0 = no spawn)
//   canSpawn           spawn enable from the spawner
//   moveSCEN           single-cycle game tick
//   damageSCEN         single-cycle damage strobe
//   damageIn[7:0]      damage applied on damageSCEN
//   playerFront[8:0]   position of the frontmost player unit
//   position[8:0]      current position
//   damageOut[7:0]     attack value, updated only on moveSCEN ticks
//   unitType[1:0]      0 when idle/dying, otherwise the live type
//   health[7:0]        remaining health
//   dead               1 while idle or dying
//   dying              1 only while in the dying state
//   reachedBase        one-cycle pulse on arrival at END_POS
module enemy_unit #(
    parameter logic [8:0] START_POS     = 9'd0,
    parameter logic [8:0] END_POS       = 9'd511,
    parameter int         ATTACK_PERIOD = 4,
    parameter int         DEAD_HOLD     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spawnSCEN,
    input  logic [1:0] spawnType,
    input  logic       canSpawn,
    input  logic       moveSCEN,
    input  logic       damageSCEN,
    input  logic [7:0] damageIn,
    input  logic [8:0] playerFront,
    output logic [8:0] position,
    output logic [7:0] damageOut,
    output logic [1:0] unitType,
    output logic [7:0] health,
    output logic       dead,
    output logic       dying,
    output logic       reachedBase
);

    localparam int ATK_W  = $clog2(ATTACK_PERIOD + 1);
    localparam int HOLD_W = $clog2(DEAD_HOLD + 1);

    localparam logic [ATK_W-1:0]  ATK_LAST  = ATK_W'(ATTACK_PERIOD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DEAD_HOLD - 1);

    typedef enum logic [3:0] {
        QI      = 4'b0001,
        QDeploy = 4'b0010,
        QAlive  = 4'b0100,
        QDying  = 4'b1000
    } state_e;

    state_e            state_q,        state_d;
    logic [8:0]        position_q,     position_d;
    logic [7:0]        damage_out_q,   damage_out_d;
    logic [1:0]        unit_type_q,    unit_type_d;
    logic [7:0]        health_q,       health_d;
    logic              dead_q,         dead_d;
    logic              dying_q,        dying_d;
    logic              reached_base_q, reached_base_d;
    logic [ATK_W-1:0]  contact_cnt_q,  contact_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q,     hold_cnt_d;
    logic [1:0]        type_q,         type_d;
    logic [7:0]        power_q,        power_d;

    logic              go_idle;
    logic              spawn_ok;
    logic [8:0]        pos_inc;
    logic [ATK_W-1:0]  contact_inc;

    assign pos_inc     = position_q + 9'd1;
    assign contact_inc = contact_cnt_q + ATK_W'(1);
    assign spawn_ok    = (state_q == QI) && spawnSCEN && canSpawn && (spawnType != 2'd0);

    // Next-state logic. Every path that ends the unit (idle, end of dying,
    // illegal encoding) raises go_idle so the reset values are written in one
    // place; an accepted spawn is applied on top of the idle values.
    always_comb begin
        state_d        = state_q;
        position_d     = position_q;
        damage_out_d   = damage_out_q;
        unit_type_d    = unit_type_q;
        health_d       = health_q;
        dead_d         = dead_q;
        dying_d        = dying_q;
        reached_base_d = 1'b0;
        contact_cnt_d  = contact_cnt_q;
        hold_cnt_d     = hold_cnt_q;
        type_d         = type_q;
        power_d        = power_q;
        go_idle        = 1'b0;

        case (state_q)
            QI: begin
                go_idle = 1'b1;
            end

            QDeploy: begin
                state_d     = QAlive;
                unit_type_d = type_q;
                dead_d      = 1'b0;
                case (type_q)
                    2'd1: begin
                        health_d = 8'd128;
                        power_d  = 8'd16;
                    end
                    2'd2: begin
                        health_d = 8'd192;
                        power_d  = 8'd32;
                    end
                    2'd3: begin
                        health_d = 8'd255;
                        power_d  = 8'd64;
                    end
                    default: go_idle = 1'b1;
                endcase
            end

            QAlive: begin
                // A lethal hit wins over a move or attack in the same cycle.
                if (damageSCEN && (health_q <= damageIn)) begin
                    state_d       = QDying;
                    health_d      = 8'd0;
                    damage_out_d  = 8'd0;
                    unit_type_d   = 2'd0;
                    dead_d        = 1'b1;
                    dying_d       = 1'b1;
                    contact_cnt_d = '0;
                    hold_cnt_d    = '0;
                end else begin
                    if (damageSCEN) begin
                        health_d = health_q - damageIn;
                    end
                    if (moveSCEN) begin
                        if (position_q < playerFront) begin
                            position_d    = pos_inc;
                            damage_out_d  = 8'd0;
                            contact_cnt_d = '0;
                            if (pos_inc == END_POS) begin
                                reached_base_d = 1'b1;
                                state_d        = QI;
                            end
                        end else if (contact_inc == ATK_LAST) begin
                            damage_out_d  = power_q;
                            contact_cnt_d = '0;
                        end else begin
                            damage_out_d  = 8'd0;
                            contact_cnt_d = contact_inc;
                        end
                    end
                end
            end

            QDying: begin
                // Entry already showed one dying cycle, so the last count is
                // DEAD_HOLD-1.
                if (hold_cnt_q == HOLD_LAST) begin
                    go_idle = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (go_idle) begin
            state_d       = QI;
            position_d    = START_POS;
            damage_out_d  = 8'd0;
            unit_type_d   = 2'd0;
            health_d      = 8'd0;
            dead_d        = 1'b1;
            dying_d       = 1'b0;
            contact_cnt_d = '0;
            hold_cnt_d    = '0;
            type_d        = 2'd0;
            power_d       = 8'd0;
        end

        if (spawn_ok) begin
            state_d = QDeploy;
            type_d  = spawnType;
            dead_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= QI;
            position_q     <= START_POS;
            damage_out_q   <= 8'd0;
            unit_type_q    <= 2'd0;
            health_q       <= 8'd0;
            dead_q         <= 1'b1;
            dying_q        <= 1'b0;
            reached_base_q <= 1'b0;
            contact_cnt_q  <= '0;
            hold_cnt_q     <= '0;
            type_q         <= 2'd0;
            power_q        <= 8'd0;
        end else begin
            state_q        <= state_d;
            position_q     <= position_d;
            damage_out_q   <= damage_out_d;
            unit_type_q    <= unit_type_d;
            health_q       <= health_d;
            dead_q         <= dead_d;
            dying_q        <= dying_d;
            reached_base_q <= reached_base_d;
            contact_cnt_q  <= contact_cnt_d;
            hold_cnt_q     <= hold_cnt_d;
            type_q         <= type_d;
            power_q        <= power_d;
        end
    end

    assign position    = position_q;
    assign damageOut   = damage_out_q;
    assign unitType    = unit_type_q;
    assign health      = health_q;
    assign dead        = dead_q;
    assign dying       = dying_q;
    assign reachedBase = reached_base_q;

endmodule

// File: tb/tb_enemy_unit.sv
// tb_enemy_unit
// Directed scenario tasks plus a randomized run against a behavioural model.
// Two instances share the inputs: dut uses the default END_POS of 511 and
// dut_end uses END_POS=5 so arrival at the base is reachable quickly.
module tb_enemy_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       spawnSCEN;
    logic [1:0] spawnType;
    logic       canSpawn;
    logic       moveSCEN;
    logic       damageSCEN;
    logic [7:0] damageIn;
    logic [8:0] playerFront;

    logic [8:0] position,    e_position;
    logic [7:0] damageOut,   e_damageOut;
    logic [1:0] unitType,    e_unitType;
    logic [7:0] health,      e_health;
    logic       dead,        e_dead;
    logic       dying,       e_dying;
    logic       reachedBase, e_reachedBase;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    enemy_unit dut (
        .clk(clk), .reset(reset), .spawnSCEN(spawnSCEN), .spawnType(spawnType),
        .canSpawn(canSpawn), .moveSCEN(moveSCEN), .damageSCEN(damageSCEN),
        .damageIn(damageIn), .playerFront(playerFront), .position(position),
        .damageOut(damageOut), .unitType(unitType), .health(health), .dead(dead),
        .dying(dying), .reachedBase(reachedBase)
    );

    enemy_unit #(.END_POS(9'd5)) dut_end (
        .clk(clk), .reset(reset), .spawnSCEN(spawnSCEN), .spawnType(spawnType),
        .canSpawn(canSpawn), .moveSCEN(moveSCEN), .damageSCEN(damageSCEN),
        .damageIn(damageIn), .playerFront(playerFront), .position(e_position),
        .damageOut(e_damageOut), .unitType(e_unitType), .health(e_health), .dead(e_dead),
        .dying(e_dying), .reachedBase(e_reachedBase)
    );

    // Behavioural model: game rules expressed directly on integers.
    typedef enum {M_IDLE, M_DEPLOY, M_ALIVE, M_DYING} mphase_e;
    typedef struct {
        mphase_e ph;
        int pos, dmg, typ, hp, pow, req, contact, hold;
        bit dead, dying, rb;
    } mdl_t;

    localparam int M_ATTACK = 4;
    localparam int M_HOLD   = 8;

    function automatic mdl_t m_idle();
        mdl_t n;
        n.ph = M_IDLE; n.pos = 0; n.dmg = 0; n.typ = 0; n.hp = 0; n.pow = 0;
        n.req = 0; n.contact = 0; n.hold = 0; n.dead = 1; n.dying = 0; n.rb = 0;
        return n;
    endfunction

    function automatic mdl_t m_step(mdl_t m, bit rst, bit sp, int st, bit cs, bit mv,
                                    bit dm, int di, int pf, int endp);
        int hp_tab[4]  = '{0, 128, 192, 255};
        int pow_tab[4] = '{0, 16, 32, 64};
        mdl_t n = m;
        n.rb = 0;
        if (rst) return m_idle();
        case (m.ph)
            M_IDLE: begin
                n = m_idle();
                if (sp && cs && st != 0) begin
                    n.ph = M_DEPLOY; n.req = st; n.dead = 0;
                end
            end
            M_DEPLOY: begin
                n.ph = M_ALIVE; n.typ = m.req; n.hp = hp_tab[m.req];
                n.pow = pow_tab[m.req]; n.dead = 0;
            end
            M_ALIVE: begin
                if (dm && m.hp <= di) begin
                    n.ph = M_DYING; n.hp = 0; n.dmg = 0; n.typ = 0;
                    n.dead = 1; n.dying = 1; n.hold = 0; n.contact = 0;
                end else begin
                    if (dm) n.hp = m.hp - di;
                    if (mv) begin
                        if (m.pos < pf) begin
                            n.pos = m.pos + 1; n.dmg = 0; n.contact = 0;
                            if (n.pos == endp) begin
                                n.rb = 1; n.ph = M_IDLE;
                            end
                        end else begin
                            n.contact = m.contact + 1;
                            n.dmg = 0;
                            if (n.contact == M_ATTACK) begin
                                n.dmg = m.pow; n.contact = 0;
                            end
                        end
                    end
                end
            end
            M_DYING: begin
                n.hold = m.hold + 1;
                if (n.hold == M_HOLD) n = m_idle();
            end
            default: n = m_idle();
        endcase
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; spawnSCEN = 1'b0; spawnType = 2'd0; canSpawn = 1'b0;
        moveSCEN = 1'b0; damageSCEN = 1'b0; damageIn = 8'd0; playerFront = 9'd0;
        tick();
        reset = 1'b0;
    endtask

    task automatic spawn(input logic [1:0] t);
        spawnSCEN = 1'b1; spawnType = t; canSpawn = 1'b1;
        tick();
        spawnSCEN = 1'b0; spawnType = 2'd0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (position !== 9'd0) begin fails++; $display("[TB] FAIL reset_position: got %0d expected 0", position); end
        tests++; if (damageOut !== 8'd0) begin fails++; $display("[TB] FAIL reset_damageOut: got %0d expected 0", damageOut); end
        tests++; if (unitType !== 2'd0) begin fails++; $display("[TB] FAIL reset_unitType: got %0d expected 0", unitType); end
        tests++; if (health !== 8'd0) begin fails++; $display("[TB] FAIL reset_health: got %0d expected 0", health); end
        tests++; if (dead !== 1'b1) begin fails++; $display("[TB] FAIL reset_dead: got %0b expected 1", dead); end
        tests++; if (dying !== 1'b0) begin fails++; $display("[TB] FAIL reset_dying: got %0b expected 0", dying); end
        tests++; if (reachedBase !== 1'b0) begin fails++; $display("[TB] FAIL reset_reachedBase: got %0b expected 0", reachedBase); end
    endtask

    task automatic test_spawn();
        do_reset();
        spawnSCEN = 1'b1; spawnType = 2'd2; canSpawn = 1'b1;
        tick();
        spawnSCEN = 1'b0;
        tests++; if (dead !== 1'b0) begin fails++; $display("[TB] FAIL deploy_dead: got %0b expected 0", dead); end
        tick();
        tests++; if (unitType !== 2'd2) begin fails++; $display("[TB] FAIL spawn_unitType: got %0d expected 2", unitType); end
        tests++; if (health !== 8'd192) begin fails++; $display("[TB] FAIL spawn_health: got %0d expected 192", health); end
        tests++; if (dead !== 1'b0) begin fails++; $display("[TB] FAIL spawn_dead: got %0b expected 0", dead); end
        tests++; if (position !== 9'd0) begin fails++; $display("[TB] FAIL spawn_position: got %0d expected 0", position); end

        do_reset();
        spawnSCEN = 1'b1; spawnType = 2'd2; canSpawn = 1'b0;
        tick();
        spawnSCEN = 1'b0;
        tick();
        tests++; if (dead !== 1'b1 || unitType !== 2'd0) begin fails++; $display("[TB] FAIL spawn_blocked_canSpawn: got dead=%0b type=%0d expected dead=1 type=0", dead, unitType); end

        do_reset();
        spawnSCEN = 1'b1; spawnType = 2'd0; canSpawn = 1'b1;
        tick();
        spawnSCEN = 1'b0;
        tick();
        tests++; if (dead !== 1'b1 || unitType !== 2'd0) begin fails++; $display("[TB] FAIL spawn_type0: got dead=%0b type=%0d expected dead=1 type=0", dead, unitType); end
    endtask

    task automatic test_move_attack();
        int exp_pos;
        int exp_dmg;
        do_reset();
        spawn(2'd1);
        playerFront = 9'd3;
        for (int i = 1; i <= 8; i++) begin
            moveSCEN = 1'b1;
            tick();
            moveSCEN = 1'b0;
            exp_pos = (i < 3) ? i : 3;
            exp_dmg = (i == 7) ? 16 : 0;
            tests++; if (position !== 9'(exp_pos)) begin fails++; $display("[TB] FAIL move_pos[%0d]: got %0d expected %0d", i, position, exp_pos); end
            tests++; if (damageOut !== 8'(exp_dmg)) begin fails++; $display("[TB] FAIL attack_dmg[%0d]: got %0d expected %0d", i, damageOut, exp_dmg); end
            if (i == 7) begin
                tick();
                tests++; if (damageOut !== 8'd16) begin fails++; $display("[TB] FAIL attack_hold: got %0d expected 16", damageOut); end
            end
        end
    endtask

    task automatic test_damage_dying();
        do_reset();
        spawn(2'd1);
        playerFront = 9'd10;
        moveSCEN = 1'b1;
        tick(); tick();
        moveSCEN = 1'b0;
        damageSCEN = 1'b1; damageIn = 8'd100;
        tick();
        damageSCEN = 1'b0;
        tests++; if (health !== 8'd28 || dead !== 1'b0) begin fails++; $display("[TB] FAIL damage_partial: got health=%0d dead=%0b expected health=28 dead=0", health, dead); end
        damageSCEN = 1'b1; damageIn = 8'd28;
        tick();
        damageSCEN = 1'b0;
        tests++; if (dead !== 1'b1 || dying !== 1'b1 || unitType !== 2'd0 || health !== 8'd0) begin fails++; $display("[TB] FAIL damage_lethal: got dead=%0b dying=%0b type=%0d health=%0d expected 1 1 0 0", dead, dying, unitType, health); end
        for (int k = 2; k <= 8; k++) begin
            moveSCEN = 1'b1; damageSCEN = 1'b1; damageIn = 8'd5;
            spawnSCEN = (k == 3); spawnType = 2'd3; canSpawn = 1'b1;
            tick();
            moveSCEN = 1'b0; damageSCEN = 1'b0; spawnSCEN = 1'b0;
            tests++; if (dying !== 1'b1 || position !== 9'd2) begin fails++; $display("[TB] FAIL dying_hold[%0d]: got dying=%0b pos=%0d expected dying=1 pos=2", k, dying, position); end
        end
        tick();
        tests++; if (dying !== 1'b0 || dead !== 1'b1 || unitType !== 2'd0 || position !== 9'd0) begin fails++; $display("[TB] FAIL dying_exit: got dying=%0b dead=%0b type=%0d pos=%0d expected 0 1 0 0", dying, dead, unitType, position); end
        tick();
        tests++; if (dead !== 1'b1) begin fails++; $display("[TB] FAIL dying_spawn_dropped: got dead=%0b expected 1", dead); end
    endtask

    task automatic test_move_kill_same();
        do_reset();
        spawn(2'd1);
        playerFront = 9'd2;
        moveSCEN = 1'b1;
        repeat (5) tick();
        damageSCEN = 1'b1; damageIn = 8'd200;
        tick();
        moveSCEN = 1'b0; damageSCEN = 1'b0;
        tests++; if (damageOut !== 8'd0 || position !== 9'd2 || dying !== 1'b1) begin fails++; $display("[TB] FAIL move_kill_same: got dmg=%0d pos=%0d dying=%0b expected 0 2 1", damageOut, position, dying); end
    endtask

    task automatic test_reach_base();
        logic exp_rb;
        do_reset();
        spawn(2'd3);
        playerFront = 9'd511;
        for (int i = 1; i <= 5; i++) begin
            moveSCEN = 1'b1;
            tick();
            moveSCEN = 1'b0;
            exp_rb = (i == 5);
            tests++; if (e_position !== 9'(i)) begin fails++; $display("[TB] FAIL base_pos[%0d]: got %0d expected %0d", i, e_position, i); end
            tests++; if (e_reachedBase !== exp_rb) begin fails++; $display("[TB] FAIL base_pulse[%0d]: got %0b expected %0b", i, e_reachedBase, exp_rb); end
        end
        tick();
        tests++; if (e_reachedBase !== 1'b0 || e_position !== 9'd0 || e_dead !== 1'b1 || e_unitType !== 2'd0) begin fails++; $display("[TB] FAIL base_after: got rb=%0b pos=%0d dead=%0b type=%0d expected 0 0 1 0", e_reachedBase, e_position, e_dead, e_unitType); end

        do_reset();
        spawn(2'd3);
        playerFront = 9'd511;
        moveSCEN = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; moveSCEN = 1'b0;
        tests++; if (e_reachedBase !== 1'b0 || e_position !== 9'd0 || e_dead !== 1'b1) begin fails++; $display("[TB] FAIL base_reset_cancel: got rb=%0b pos=%0d dead=%0b expected 0 0 1", e_reachedBase, e_position, e_dead); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        spawn(2'd1);
        playerFront = 9'd100;
        moveSCEN = 1'b1;
        repeat (40) tick();
        moveSCEN = 1'b0;
        damageSCEN = 1'b1; damageIn = 8'd38;
        tick();
        damageSCEN = 1'b0;
        tests++; if (position !== 9'd40 || health !== 8'd90) begin fails++; $display("[TB] FAIL mid_setup: got pos=%0d health=%0d expected 40 90", position, health); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (position !== 9'd0 || health !== 8'd0 || dead !== 1'b1 || unitType !== 2'd0 || damageOut !== 8'd0) begin fails++; $display("[TB] FAIL mid_reset_alive: got pos=%0d health=%0d dead=%0b type=%0d dmg=%0d expected 0 0 1 0 0", position, health, dead, unitType, damageOut); end
        spawn(2'd2);
        tests++; if (unitType !== 2'd2 || health !== 8'd192) begin fails++; $display("[TB] FAIL mid_respawn1: got type=%0d health=%0d expected 2 192", unitType, health); end
        damageSCEN = 1'b1; damageIn = 8'd255;
        tick();
        damageSCEN = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (dying !== 1'b0 || dead !== 1'b1 || position !== 9'd0 || unitType !== 2'd0) begin fails++; $display("[TB] FAIL mid_reset_dying: got dying=%0b dead=%0b pos=%0d type=%0d expected 0 1 0 0", dying, dead, position, unitType); end
        spawn(2'd3);
        tests++; if (unitType !== 2'd3 || health !== 8'd255 || dead !== 1'b0) begin fails++; $display("[TB] FAIL mid_respawn2: got type=%0d health=%0d dead=%0b expected 3 255 0", unitType, health, dead); end
    endtask

    task automatic test_random();
        mdl_t m1, m2, m;
        logic [8:0] g_pos;
        logic [7:0] g_dmg, g_hp;
        logic [1:0] g_typ;
        logic       g_dead, g_dying, g_rb;
        do_reset();
        m1 = m_idle();
        m2 = m_idle();
        playerFront = 9'd8;
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 299) == 0);
            spawnSCEN  = ($urandom_range(0, 3) == 0);
            spawnType  = 2'($urandom_range(0, 3));
            canSpawn   = ($urandom_range(0, 4) != 0);
            moveSCEN   = 1'($urandom_range(0, 1));
            damageSCEN = ($urandom_range(0, 9) == 0);
            damageIn   = 8'($urandom_range(0, 90));
            if ($urandom_range(0, 49) == 0) playerFront = 9'($urandom_range(0, 30));
            m1 = m_step(m1, reset, spawnSCEN, int'(spawnType), canSpawn, moveSCEN,
                        damageSCEN, int'(damageIn), int'(playerFront), 511);
            m2 = m_step(m2, reset, spawnSCEN, int'(spawnType), canSpawn, moveSCEN,
                        damageSCEN, int'(damageIn), int'(playerFront), 5);
            tick();
            for (int d = 0; d < 2; d++) begin
                m       = (d == 0) ? m1 : m2;
                g_pos   = (d == 0) ? position    : e_position;
                g_dmg   = (d == 0) ? damageOut   : e_damageOut;
                g_hp    = (d == 0) ? health      : e_health;
                g_typ   = (d == 0) ? unitType    : e_unitType;
                g_dead  = (d == 0) ? dead        : e_dead;
                g_dying = (d == 0) ? dying       : e_dying;
                g_rb    = (d == 0) ? reachedBase : e_reachedBase;
                tests++; if (g_pos !== 9'(m.pos)) begin fails++; $display("[TB] FAIL rand_pos dut%0d cyc%0d: got %0d expected %0d", d, c, g_pos, m.pos); end
                tests++; if (g_dying !== m.dying) begin fails++; $display("[TB] FAIL rand_dying dut%0d cyc%0d: got %0b expected %0b", d, c, g_dying, m.dying); end
                tests++; if (g_rb !== m.rb) begin fails++; $display("[TB] FAIL rand_rb dut%0d cyc%0d: got %0b expected %0b", d, c, g_rb, m.rb); end
                if (!m.rb) begin
                    tests++; if (g_dmg !== 8'(m.dmg)) begin fails++; $display("[TB] FAIL rand_dmg dut%0d cyc%0d: got %0d expected %0d", d, c, g_dmg, m.dmg); end
                    tests++; if (g_dead !== m.dead) begin fails++; $display("[TB] FAIL rand_dead dut%0d cyc%0d: got %0b expected %0b", d, c, g_dead, m.dead); end
                    if (m.ph != M_DEPLOY) begin
                        tests++; if (g_hp !== 8'(m.hp)) begin fails++; $display("[TB] FAIL rand_hp dut%0d cyc%0d: got %0d expected %0d", d, c, g_hp, m.hp); end
                        tests++; if (g_typ !== 2'(m.typ)) begin fails++; $display("[TB] FAIL rand_type dut%0d cyc%0d: got %0d expected %0d", d, c, g_typ, m.typ); end
                    end
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_move_attack();
        test_damage_dying();
        test_move_kill_same();
        test_reach_base();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/enemy_unit.md
Name: enemy_unit

Overview:
Enemy-side counterpart of the player unit. It spawns at the enemy end of the lane and advances toward increasing position, one step per moveSCEN tick. It attacks the frontmost player unit on a cooldown, takes damage from the battlefront logic, and either dies (passing through a timed dying state) or reaches the player base. The battlefront calculator drives moveSCEN, damageSCEN and damageIn, and consumes position, damageOut, unitType and dead.

Parameters:
START_POS, 9'd0, spawn position (enemy end of lane)
END_POS, 9'd511, player-base position; reaching it ends the unit
ATTACK_PERIOD, 4, moveSCEN ticks in contact per delivered attack (>=1)
DEAD_HOLD, 8, clk cycles spent in dying state (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
spawnSCEN  in  1  single-cycle spawn request
spawnType  in  2  requested type 1-3; 0 means no spawn
canSpawn  in  1  spawn enable from spawner
moveSCEN  in  1  single-cycle game tick from battlefront calculator
damageSCEN  in  1  single-cycle damage strobe
damageIn  in  8  damage to apply on damageSCEN
playerFront  in  9  position of the frontmost player unit
position  out  9  current position
damageOut  out  8  attack value presented to the battlefront calculator
unitType  out  2  00 dead/idle, 01-11 live type
health  out  8  remaining health
dead  out  1  1 in idle/dying, 0 while deploying or alive
dying  out  1  1 only in the dying state (death-sprite select)
reachedBase  out  1  one-cycle pulse when the unit reaches END_POS

Behaviour:
- Single clk domain; all state is registered. Reset is sampled on the clk edge only and has priority over every other input.
- Reset values: state QI, position=START_POS, damageOut=0, unitType=0, health=0, dead=1, dying=0, reachedBase=0, contact counter=0.
- States: QI, QDeploy, QAlive, QDying (one-hot).
- QI:
  - Outputs hold their reset values.
  - If spawnSCEN && canSpawn && spawnType!=0: latch spawnType and go to QDeploy. Otherwise stay.
- QDeploy: one cycle, then QAlive. Loads by type:
  - type1: health 128, power 16
  - type2: health 192, power 32
  - type3: health 255, power 64
  - unitType=latched type, dead=0.
- QAlive, damage (evaluated first):
  - If damageSCEN && health<=damageIn: health=0, damageOut=0, dying=1, dead=1, unitType=0; go to QDying. Any moveSCEN in the same cycle is ignored (no move, no attack).
  - If damageSCEN otherwise: health -= damageIn (no underflow possible).
- QAlive, moveSCEN (unit survived this cycle):
  - If position < playerFront: position+1, damageOut=0, contact counter=0.
  - Else (contact): counter+1. When counter reaches ATTACK_PERIOD: damageOut=power, counter=0. Otherwise damageOut=0.
  - damageOut changes only on moveSCEN cycles and holds between ticks.
  - If the new position equals END_POS: pulse reachedBase for one cycle and go to QI next cycle; outputs return to reset values.
- QDying:
  - Counter runs DEAD_HOLD cycles, then the unit goes to QI with dying=0.
  - moveSCEN, damageSCEN and spawnSCEN are all ignored; position is frozen.
- Spawn requests arriving in QDeploy, QAlive or QDying are dropped, not queued.
- Unreachable or illegal state encodings recover to QI.
- Reset mid-operation: the next edge yields reset values from any state, including mid-dying. A pending reachedBase pulse is cancelled.

Test Plan:
- Reset, then spawnSCEN=1, spawnType=2, canSpawn=1 for one cycle -> edge+1 in QDeploy; edge+2 unitType=2, health=192, dead=0, position=0. Repeat with canSpawn=0 or spawnType=0 -> stays in QI.
- Type1, playerFront=3, 8 moveSCEN pulses -> position 1,2,3 after pulses 1-3; damageOut=0 on pulses 4-6, 16 on pulse 7, 0 on pulse 8.
- Type1, damageSCEN with damageIn=100 -> health=28, still alive. damageIn=28 -> dead=1, dying=1, unitType=0 for 8 cycles, then QI. A spawnSCEN issued during dying is ignored.
- In contact on an attack tick, assert moveSCEN and a lethal damageSCEN together -> damageOut=0, position unchanged, enters QDying.
- END_POS=5, playerFront=511, 5 moveSCEN pulses -> position=5 with reachedBase high for exactly one cycle; next cycle position=0, dead=1, unitType=0.
- reset asserted in QAlive (position=40, health=90) and again in QDying -> next edge gives all reset values; the unit respawns normally afterward.
